// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug dump transmitter: state encoding and word-index regions.
// Optional feature macro: DEBUG_TX_CHECKSUM_EN (adds trailing XOR checksum byte).
package debug_pkg;

    localparam int unsigned DEF_BITS_SIZE     = 32;
    localparam int unsigned DEF_SIZE_TRAMA    = 8;
    localparam int unsigned DEF_NUM_REGISTERS = 32;
    localparam int unsigned DEF_SIZE_MEM_DATA = 16;

    // Words 0 and 1 are PC and cycle count; bank registers start here.
    localparam int unsigned REG_BASE = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_ADDR,
        ST_LATCH,
        ST_SEND,
        ST_WAIT,
`ifdef DEBUG_TX_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_FIN
    } dump_state_t;

    function automatic int unsigned mem_base(input int unsigned num_registers);
        return REG_BASE + num_registers;
    endfunction

    function automatic int unsigned total_words(input int unsigned num_registers,
                                                input int unsigned size_mem_data);
        return REG_BASE + num_registers + size_mem_data;
    endfunction

    function automatic int unsigned bytes_per_word(input int unsigned bits_size,
                                                   input int unsigned size_trama);
        return bits_size / size_trama;
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Holds one word and presents it as UART frames, least-significant frame first.
module debug_word_serializer
    import debug_pkg::*;
#(
    parameter int unsigned BITS_SIZE  = DEF_BITS_SIZE,
    parameter int unsigned SIZE_TRAMA = DEF_SIZE_TRAMA
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [BITS_SIZE-1:0]  i_word,
    input  logic                  i_advance,
    output logic [SIZE_TRAMA-1:0] o_byte,
    output logic                  o_last
);

    localparam int unsigned BPW    = bytes_per_word(BITS_SIZE, SIZE_TRAMA);
    localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [BITS_SIZE-1:0] shift_q;
    logic [BIDX_W-1:0]    byte_idx;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            shift_q  <= '0;
            byte_idx <= '0;
        end else if (i_load) begin
            shift_q  <= i_word;
            byte_idx <= '0;
        end else if (i_advance) begin
            shift_q  <= shift_q >> SIZE_TRAMA;
            byte_idx <= o_last ? '0 : byte_idx + BIDX_W'(1);
        end
    end

    assign o_byte = shift_q[SIZE_TRAMA-1:0];
    assign o_last = (byte_idx == BIDX_W'(BPW - 1));

endmodule

// File: rtl/debug_dump_tx.sv
// Streams a coherent snapshot of PC, cycle count, bank registers and data memory to the UART TX.
// Optional feature macro: DEBUG_TX_CHECKSUM_EN (trailing XOR-of-all-bytes frame).
module debug_dump_tx
    import debug_pkg::*;
#(
    parameter int unsigned BITS_SIZE     = DEF_BITS_SIZE,
    parameter int unsigned SIZE_TRAMA    = DEF_SIZE_TRAMA,
    parameter int unsigned NUM_REGISTERS = DEF_NUM_REGISTERS,
    parameter int unsigned SIZE_MEM_DATA = DEF_SIZE_MEM_DATA
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [BITS_SIZE-1:0]             i_mips_pc,
    input  logic [BITS_SIZE-1:0]             i_clk_count,
    input  logic [BITS_SIZE-1:0]             i_data_bankregisters,
    input  logic [BITS_SIZE-1:0]             i_data_mem,
    output logic [$clog2(NUM_REGISTERS)-1:0] o_select_addr_registers,
    output logic [$clog2(SIZE_MEM_DATA)-1:0] o_select_addr_memdata,
    output logic                             o_tx_start,
    output logic [SIZE_TRAMA-1:0]            o_tx_data,
    input  logic                             i_tx_done,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int unsigned TOTAL_WORDS = total_words(NUM_REGISTERS, SIZE_MEM_DATA);
    localparam int unsigned MEM_BASE    = mem_base(NUM_REGISTERS);
    localparam int unsigned WIDX_W      = $clog2(TOTAL_WORDS);
    localparam int unsigned RA_W        = $clog2(NUM_REGISTERS);
    localparam int unsigned MA_W        = $clog2(SIZE_MEM_DATA);

`ifdef DEBUG_TX_CHECKSUM_EN
    localparam dump_state_t AFTER_DATA = ST_CKSUM;
`else
    localparam dump_state_t AFTER_DATA = ST_FIN;
`endif

    dump_state_t          state, state_next;
    logic [WIDX_W-1:0]    word_idx;
    logic [BITS_SIZE-1:0] pc_snap, clk_snap;
    logic [RA_W-1:0]      reg_addr_q;
    logic [MA_W-1:0]      mem_addr_q;
    logic                 in_reg, in_mem;
    logic                 ser_load, ser_advance, ser_last;
    logic [BITS_SIZE-1:0] ser_word;
    logic [SIZE_TRAMA-1:0] ser_byte;
    logic                 word_advance;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [SIZE_TRAMA-1:0] xor_q;
    logic                  cks_phase;
`endif

    assign in_reg = (word_idx >= WIDX_W'(REG_BASE)) && (word_idx < WIDX_W'(MEM_BASE));
    assign in_mem = (word_idx >= WIDX_W'(MEM_BASE));

    debug_word_serializer #(
        .BITS_SIZE (BITS_SIZE),
        .SIZE_TRAMA(SIZE_TRAMA)
    ) u_serializer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (ser_load),
        .i_word   (ser_word),
        .i_advance(ser_advance),
        .o_byte   (ser_byte),
        .o_last   (ser_last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            word_idx   <= '0;
            pc_snap    <= '0;
            clk_snap   <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
            xor_q      <= '0;
            cks_phase  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                ST_SNAP: begin
                    pc_snap   <= i_mips_pc;
                    clk_snap  <= i_clk_count;
                    word_idx  <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
                    xor_q     <= '0;
                    cks_phase <= 1'b0;
`endif
                end
                ST_ADDR: begin
                    if (in_reg)
                        reg_addr_q <= RA_W'(word_idx - WIDX_W'(REG_BASE));
                    else if (in_mem)
                        mem_addr_q <= MA_W'(word_idx - WIDX_W'(MEM_BASE));
                end
`ifdef DEBUG_TX_CHECKSUM_EN
                ST_SEND:  if (!cks_phase) xor_q <= xor_q ^ ser_byte;
                ST_CKSUM: cks_phase <= 1'b1;
`endif
                default: ;
            endcase
            if (word_advance)
                word_idx <= word_idx + WIDX_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        ser_load     = 1'b0;
        ser_advance  = 1'b0;
        ser_word     = '0;
        word_advance = 1'b0;
        o_tx_start   = 1'b0;
        o_done       = 1'b0;
        case (state)
            ST_IDLE:  if (i_start) state_next = ST_SNAP;
            ST_SNAP:  state_next = ST_ADDR;
            ST_ADDR:  state_next = ST_LATCH;
            ST_LATCH: begin
                ser_load = 1'b1;
                if (word_idx == WIDX_W'(0))      ser_word = pc_snap;
                else if (word_idx == WIDX_W'(1)) ser_word = clk_snap;
                else if (in_reg)                 ser_word = i_data_bankregisters;
                else                             ser_word = i_data_mem;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                o_tx_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    ser_advance = 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                    if (cks_phase) state_next = ST_FIN; else
`endif
                    if (!ser_last) state_next = ST_SEND;
                    else if (word_idx != WIDX_W'(TOTAL_WORDS - 1)) begin
                        word_advance = 1'b1;
                        state_next   = ST_ADDR;
                    end else
                        state_next = AFTER_DATA;
                end
            end
`ifdef DEBUG_TX_CHECKSUM_EN
            // Checksum frame reuses the serializer so SEND/WAIT handle it unchanged.
            ST_CKSUM: begin
                ser_load   = 1'b1;
                ser_word   = BITS_SIZE'(xor_q);
                state_next = ST_SEND;
            end
`endif
            ST_FIN: begin
                o_done     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_busy    = (state != ST_IDLE) && (state != ST_FIN);
    assign o_tx_data = (state == ST_SEND || state == ST_WAIT) ? ser_byte : '0;
    assign o_select_addr_registers = reg_addr_q;
    assign o_select_addr_memdata   = mem_addr_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed self-checking bench for debug_dump_tx (default build, checksum disabled).
module tb_debug_dump_tx;

    logic        wire_clk_wz = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_mips_pc;
    logic [31:0] i_clk_count;
    logic [31:0] i_data_bankregisters;
    logic [31:0] i_data_mem;
    logic [4:0]  o_select_addr_registers;
    logic [3:0]  o_select_addr_memdata;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;

    int checks   = 0;
    int failures = 0;

    always #5 wire_clk_wz = ~wire_clk_wz;

    debug_dump_tx #(
        .BITS_SIZE    (32),
        .SIZE_TRAMA   (8),
        .NUM_REGISTERS(32),
        .SIZE_MEM_DATA(16)
    ) dut (
        .i_clk                  (wire_clk_wz),
        .i_reset                (i_reset),
        .i_start                (i_start),
        .i_mips_pc              (i_mips_pc),
        .i_clk_count            (i_clk_count),
        .i_data_bankregisters   (i_data_bankregisters),
        .i_data_mem             (i_data_mem),
        .o_select_addr_registers(o_select_addr_registers),
        .o_select_addr_memdata  (o_select_addr_memdata),
        .o_tx_start             (o_tx_start),
        .o_tx_data              (o_tx_data),
        .i_tx_done              (i_tx_done),
        .o_busy                 (o_busy),
        .o_done                 (o_done)
    );

    // Combinational register bank and data memory models.
    always_comb begin
        i_data_bankregisters = 32'(o_select_addr_registers) * 32'h0101_0101;
        i_data_mem           = 32'hDEAD_0000 + 32'(o_select_addr_memdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int n);
        int          w;
        logic [31:0] v;
        w = n / 4;
        if (w == 0)       v = 32'h0000_0040;
        else if (w == 1)  v = 32'h0000_0012;
        else if (w < 34)  v = 32'(w - 2) * 32'h0101_0101;
        else              v = 32'hDEAD_0000 + 32'(w - 34);
        return v[8*(n%4) +: 8];
    endfunction

    // Runs one dump. slow_n: bytes answered after 1000 cycles; restart_at/reset_at: byte index or -1.
    task automatic run_dump(input int slow_n, input int restart_at, input int reset_at, input bit pc_bump);
        int         nb = 0;
        int         nd = 0;
        int         cyc = 0;
        int         delay;
        logic [7:0] held;
        bit         stable;
        i_mips_pc = 32'h40;
        @(negedge wire_clk_wz); i_start = 1'b1;
        @(negedge wire_clk_wz); i_start = 1'b0;
        chk("busy_after_start", {31'b0, o_busy}, 32'd1);
        if (pc_bump) begin
            @(negedge wire_clk_wz);
            i_mips_pc = 32'h44;
        end
        while (nd == 0 && cyc < 60000) begin
            if (o_done) begin
                nd++;
                chk("busy_low_at_done", {31'b0, o_busy}, 32'd0);
            end
            if (o_tx_start) begin
                chk($sformatf("byte%0d", nb), {24'b0, o_tx_data}, {24'b0, exp_byte(nb)});
                nb++;
                if (nb - 1 == reset_at) begin
                    @(negedge wire_clk_wz); i_reset = 1'b0;
                    @(negedge wire_clk_wz);
                    chk("rst_tx_start", {31'b0, o_tx_start}, 32'd0);
                    chk("rst_busy", {31'b0, o_busy}, 32'd0);
                    chk("rst_done", {31'b0, o_done}, 32'd0);
                    chk("rst_tx_data", {24'b0, o_tx_data}, 32'd0);
                    chk("rst_addr_reg", {27'b0, o_select_addr_registers}, 32'd0);
                    chk("rst_addr_mem", {28'b0, o_select_addr_memdata}, 32'd0);
                    i_reset = 1'b1;
                    stable = 1'b1;
                    repeat (40) begin
                        @(negedge wire_clk_wz);
                        if (o_tx_start || o_busy) stable = 1'b0;
                    end
                    chk("quiet_after_reset", {31'b0, stable}, 32'd1);
                    return;
                end
                if (nb - 1 == restart_at) i_start = 1'b1;
                held   = o_tx_data;
                stable = 1'b1;
                delay  = (nb <= slow_n) ? 1000 : 1 + (nb % 3);
                repeat (delay) begin
                    @(negedge wire_clk_wz);
                    i_start = 1'b0;
                    if (o_tx_start || o_tx_data !== held) stable = 1'b0;
                end
                chk($sformatf("hold_wait%0d", nb - 1), {31'b0, stable}, 32'd1);
                i_tx_done = 1'b1;
                @(negedge wire_clk_wz);
                i_tx_done = 1'b0;
                cyc += delay + 1;
            end else begin
                @(negedge wire_clk_wz);
                cyc++;
            end
        end
        chk("dump_finished_in_budget", {31'b0, (nd != 0)}, 32'd1);
        repeat (20) begin
            @(negedge wire_clk_wz);
            if (o_done) nd++;
            if (o_tx_start) nb++;
        end
        chk("byte_count", 32'(nb), 32'd200);
        chk("done_count", 32'(nd), 32'd1);
        chk("idle_busy", {31'b0, o_busy}, 32'd0);
    endtask

    initial begin
        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_mips_pc   = 32'h40;
        i_clk_count = 32'h12;
        i_tx_done   = 1'b0;
        repeat (3) @(negedge wire_clk_wz);
        chk("reset_tx_start", {31'b0, o_tx_start}, 32'd0);
        chk("reset_tx_data", {24'b0, o_tx_data}, 32'd0);
        chk("reset_busy", {31'b0, o_busy}, 32'd0);
        chk("reset_done", {31'b0, o_done}, 32'd0);
        i_reset = 1'b1;

        // Stray tx_done while idle must not start anything.
        @(negedge wire_clk_wz); i_tx_done = 1'b1;
        @(negedge wire_clk_wz); i_tx_done = 1'b0;
        chk("idle_tx_done_busy", {31'b0, o_busy}, 32'd0);
        chk("idle_tx_done_start", {31'b0, o_tx_start}, 32'd0);

        run_dump(0, -1, -1, 1'b0);    // fast handshake
        run_dump(20, -1, -1, 1'b0);   // slow UART on first bytes
        run_dump(0, 37, -1, 1'b0);    // ignored restart request
        run_dump(0, -1, -1, 1'b1);    // PC changes after snapshot
        run_dump(0, -1, 90, 1'b0);    // reset mid-dump
        run_dump(0, -1, -1, 1'b0);    // fresh dump after abort

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
